led_frame_encoder: RTL and testbench
====================================

// Module: led_frame_encoder
// PURPOSE
//  Serialises one parallel data word into a Manchester-coded bit stream that drives an LED (visible-light link).
//  Sits between frame-producing logic (fed by the OSCH on-chip oscillator clock) and the LED pad.
//  Handshake: start requests a frame; irq flags frame completion.
// PARAMETERS
//  FRAME_SIZE        16     data word width in bits; default taken from `FRAME_SIZE in definitions.v
//  CLKS_PER_HALFBIT  1024   clock cycles per Manchester half-bit; must be >= 1
//  PREAMBLE_BITS     8      preamble length in bits
//  PREAMBLE          8'hAB  preamble pattern, sent MSB first
// PORTS
//  clock    in   1           system clock (OSCH output); all logic on the rising edge
//  reset_n  in   1           asynchronous, active-low reset
//  start    in   1           level request; sampled only in IDLE
//  data     in   FRAME_SIZE  payload; latched on the accepting edge; MSB sent first
//  led      out  1           Manchester line output; idle level 0
//  irq      out  1           one-cycle completion pulse
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, led=0, irq=0, all counters and shift register cleared.
//  - FSM states: IDLE -> PREAMBLE -> DATA [-> PARITY] -> DONE -> IDLE.
//  - IDLE: led=0. On a rising edge with start=1: latch data, load the preamble, go to PREAMBLE.
//  - Encoding: logical 1 = low then high; logical 0 = high then low.
//    Each half-bit lasts CLKS_PER_HALFBIT cycles, so each bit lasts 2*CLKS_PER_HALFBIT cycles.
//  - Output timing: led is a registered output. The first half-bit of preamble bit 0 starts on the cycle after acceptance.
//  - Sending order: PREAMBLE_BITS bits of PREAMBLE, then FRAME_SIZE payload bits (MSB first), then the optional parity bit.
//  - DONE: lasts one cycle. During it irq=1 and led=0; the FSM then returns to IDLE.
//  - irq=0 in every other state.
//  - Frame length from acceptance to the irq cycle: (PREAMBLE_BITS + FRAME_SIZE [+1]) * 2 * CLKS_PER_HALFBIT cycles.
//  - start and data are ignored outside IDLE. Changing data mid-frame does not affect the frame in flight.
//  - If start is still 1 in the IDLE cycle after DONE, the next frame begins. Back-to-back frames therefore have a 1-cycle gap (DONE) plus the IDLE sample cycle.
//  - Reset asserted mid-frame aborts the frame immediately: led=0, no irq is issued.
//  - Counter widths: half-bit counter is $clog2(CLKS_PER_HALFBIT) bits; bit counter is $clog2(PREAMBLE_BITS+FRAME_SIZE+1) bits.
//    Counters never wrap inside a frame.
// CONFIGURATION
//  - Macro ENCODER_PARITY_EN defined: an even-parity bit is appended after the payload.
//    The parity bit is the XOR of the latched data, Manchester-coded like any other bit. The PARITY state exists.
//  - Macro not defined: no parity bit and no PARITY state; DATA goes directly to DONE.
// STRUCTURE
//  - definitions.v holds `FRAME_SIZE, the state encodings (IDLE/PREAMBLE/DATA/PARITY/DONE) and the default PREAMBLE.
//  - One sub-module: halfbit_tick_gen, a counter that emits a 1-cycle tick every CLKS_PER_HALFBIT cycles.
//    It is cleared on IDLE->PREAMBLE so the frame phase is aligned to acceptance.
//  - The top level contains the FSM, the shift register, the half-bit phase flop and the led/irq output registers.
// TESTING (CLKS_PER_HALFBIT=2, FRAME_SIZE=16, PREAMBLE=8'hAB)
//  1. Reset: reset_n=0 mid-operation -> led=0, irq=0 immediately; start ignored while reset_n=0.
//  2. Single frame, data=16'h5555, start pulsed for 1 cycle:
//     led = Manchester(8'hAB) then Manchester(16'h5555), i.e. 4-cycle bits with the 0 = "1100", 1 = "0011" pattern.
//     irq pulses exactly once, at 96 cycles after acceptance (100 with parity).
//  3. Continuous start=1 while the driver drops start on irq (top-level usage):
//     consecutive identical frames, each separated by DONE+IDLE; irq count equals frame count.
//  4. data changed from 16'h5555 to 16'hFFFF mid-frame -> the frame in flight still carries 16'h5555;
//     the next frame carries 16'hFFFF.
//  5. ENCODER_PARITY_EN with data=16'h0001 -> parity bit 1 is sent after the LSB;
//     with data=16'h0003 -> parity bit 0. Without the macro, irq arrives 4 cycles earlier.
//  6. Reset asserted at payload bit 5 -> led=0 and no irq; after release with start=1 -> a full new frame with preamble.

Source files
------------

// File: rtl/led_frame_encoder_pkg.sv
// Shared definitions for the LED Manchester frame encoder: default frame width,
// default preamble pattern, FSM state encodings and a small Manchester helper.
// Build option: define ENCODER_PARITY_EN to add the PARITY state (even-parity bit).
package led_frame_encoder_pkg;

  localparam int         FRAME_SIZE_DEF = 16;
  localparam logic [7:0] PREAMBLE_DEF   = 8'hAB;

  // Fixed encodings so state values stay stable whether or not PARITY is built.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
`ifdef ENCODER_PARITY_EN
    ST_PARITY   = 3'd3,
`endif
    ST_DONE     = 3'd4
  } state_t;

  // Manchester: a 1 is sent low-then-high, a 0 high-then-low, so the first
  // half-bit is always the complement of the bit value.
  function automatic logic first_half(input logic bit_val);
    return ~bit_val;
  endfunction

endpackage

// File: rtl/led_frame_encoder_tick_gen.sv
// Purpose:      half-bit timebase; 1-cycle tick every CLKS_PER_HALFBIT enabled cycles.
// Latency:      first tick CLKS_PER_HALFBIT cycles after clear; tick is combinational on the count.
// Backpressure: none; counter only advances while enable=1, clear forces phase zero.
// Ports: clock, reset_n (async active-low), clear (restart phase), enable (count), tick (out).
module halfbit_tick_gen #(
  parameter int CLKS_PER_HALFBIT = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // A one-cycle half-bit still needs a 1-bit counter that simply stays at 0.
  localparam int CW = (CLKS_PER_HALFBIT > 1) ? $clog2(CLKS_PER_HALFBIT) : 1;

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == CW'(CLKS_PER_HALFBIT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_frame_encoder.sv
// Purpose:      serialise one data word as Manchester-coded preamble + payload (+ parity) onto an LED.
// Latency:      led starts the cycle after acceptance; irq (1 cycle) after (PREAMBLE_BITS+FRAME_SIZE[+1])*2*CLKS_PER_HALFBIT cycles.
// Backpressure: start is a level request sampled only in IDLE; start/data are ignored while a frame runs.
// Ports: clock, reset_n (async active-low), start, data[FRAME_SIZE-1:0] -> led (idle 0), irq (completion pulse).
// Build option: ENCODER_PARITY_EN appends an even-parity bit after the payload.
module led_frame_encoder
  import led_frame_encoder_pkg::*;
#(
  parameter int                       FRAME_SIZE       = FRAME_SIZE_DEF,
  parameter int                       CLKS_PER_HALFBIT = 1024,
  parameter int                       PREAMBLE_BITS    = 8,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE         = PREAMBLE_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [FRAME_SIZE-1:0] data,
  output logic                  led,
  output logic                  irq
);

  localparam int TOTAL_BITS = PREAMBLE_BITS + FRAME_SIZE;
  localparam int BW         = $clog2(TOTAL_BITS + 1);

  state_t                state;
  logic [TOTAL_BITS-1:0] sreg;     // preamble and payload, MSB is the bit on the wire
  logic [BW-1:0]         bit_cnt;  // index of the bit currently on the wire
  logic                  phase;    // 0 = first half-bit, 1 = second half-bit
  logic                  tick;
  logic                  accept;
  logic                  active;
  logic                  fill_bit;

  assign accept = (state == ST_IDLE) && start;
  assign active = (state != ST_IDLE) && (state != ST_DONE);

`ifdef ENCODER_PARITY_EN
  logic par_q;
  // Shifting the parity in behind the payload makes it arrive at the MSB
  // exactly when the last payload bit has gone, so PARITY needs no special path.
  assign fill_bit = par_q;
`else
  assign fill_bit = 1'b0;
`endif

  halfbit_tick_gen #(
    .CLKS_PER_HALFBIT(CLKS_PER_HALFBIT)
  ) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (accept),
    .enable (active),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      led     <= 1'b0;
      irq     <= 1'b0;
`ifdef ENCODER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      irq <= 1'b0;
      case (state)
        ST_IDLE: begin
          led     <= 1'b0;
          phase   <= 1'b0;
          bit_cnt <= '0;
          if (start) begin
            sreg  <= {PREAMBLE, data};
`ifdef ENCODER_PARITY_EN
            par_q <= ^data;
`endif
            // Registered so the first half of preamble bit 0 is on the pin
            // in the very next cycle.
            led   <= first_half(PREAMBLE[PREAMBLE_BITS-1]);
            state <= ST_PREAMBLE;
          end
        end

        ST_DONE: begin
          led   <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          if (tick) begin
            if (!phase) begin
              phase <= 1'b1;
              led   <= sreg[TOTAL_BITS-1];
            end else begin
              // Bit boundary: move to the next bit; transitions below may
              // override led/irq when the frame ends.
              phase   <= 1'b0;
              sreg    <= {sreg[TOTAL_BITS-2:0], fill_bit};
              bit_cnt <= bit_cnt + 1'b1;
              led     <= first_half(sreg[TOTAL_BITS-2]);
              case (state)
                ST_PREAMBLE: begin
                  if (bit_cnt == BW'(PREAMBLE_BITS - 1)) state <= ST_DATA;
                end
                ST_DATA: begin
                  if (bit_cnt == BW'(TOTAL_BITS - 1)) begin
`ifdef ENCODER_PARITY_EN
                    state <= ST_PARITY;
`else
                    state <= ST_DONE;
                    led   <= 1'b0;
                    irq   <= 1'b1;
`endif
                  end
                end
`ifdef ENCODER_PARITY_EN
                ST_PARITY: begin
                  state <= ST_DONE;
                  led   <= 1'b0;
                  irq   <= 1'b1;
                end
`endif
                default: begin
                  state <= ST_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_encoder.sv
// Bench for led_frame_encoder with CLKS_PER_HALFBIT=2, FRAME_SIZE=16, PREAMBLE=8'hAB.
// A frame-level reference model predicts led/irq for every cycle from the time since acceptance.
module tb_led_frame_encoder;

  localparam int C  = 2;
  localparam int FS = 16;
  localparam int PB = 8;
`ifdef ENCODER_PARITY_EN
  localparam int   NB        = PB + FS + 1;
  localparam int   EXP_LAT   = 100;
  localparam logic LAST_0001 = 1'b1;
  localparam logic LAST_0003 = 1'b0;
`else
  localparam int   NB        = PB + FS;
  localparam int   EXP_LAT   = 96;
  localparam logic LAST_0001 = 1'b1;
  localparam logic LAST_0003 = 1'b1;
`endif
  localparam int L = NB * 2 * C;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [FS-1:0] data;
  logic          led;
  logic          irq;

  int            n_cmp;
  int            n_err;
  int            m_t;
  bit            m_act;
  logic [NB-1:0] m_bits;
  int            m_accepts;
  int            m_irqs;
  int            dut_irqs;
  int            lat;
  int            base;
  int            acc;
  int            k;

  led_frame_encoder #(
    .FRAME_SIZE      (FS),
    .CLKS_PER_HALFBIT(C),
    .PREAMBLE_BITS   (PB),
    .PREAMBLE        (8'hAB)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .data   (data),
    .led    (led),
    .irq    (irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bits on the wire for one frame, in sending order from the MSB down.
  function automatic logic [NB-1:0] frame_bits(input logic [FS-1:0] d);
    logic [7:0] pre;
`ifdef ENCODER_PARITY_EN
    logic p;
    pre = 8'hAB;
    p   = 1'b0;
    for (int i = 0; i < FS; i++) p = p ^ d[i];
    return {pre, d, p};
`else
    pre = 8'hAB;
    return {pre, d};
`endif
  endfunction

  // Model of one rising edge: m_t counts edges since acceptance,
  // 0..L-1 = bits on the wire, L = completion cycle, L+1 = idle again.
  task automatic model_edge();
    if (!reset_n) begin
      m_act = 1'b0;
    end else if ((!m_act || m_t > L) && start) begin
      m_act  = 1'b1;
      m_t    = 0;
      m_bits = frame_bits(data);
      m_accepts++;
    end else if (m_act && m_t <= L) begin
      m_t++;
    end
  endtask

  task automatic step();
    logic e_led;
    logic e_irq;
    logic b;
    int   bi;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    e_led = 1'b0;
    e_irq = 1'b0;
    if (reset_n && m_act) begin
      if (m_t < L) begin
        bi    = m_t / (2 * C);
        b     = m_bits[NB-1-bi];
        e_led = (((m_t / C) % 2) == 1) ? b : ~b;
      end else if (m_t == L) begin
        e_irq = 1'b1;
        m_irqs++;
      end
    end
    chk("led", 32'(led), 32'(e_led));
    chk("irq", 32'(irq), 32'(e_irq));
    if (irq) dut_irqs++;
  endtask

  task automatic wait_irq(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!irq && n < L + 20);
    chk({tag, "_irq_seen"}, 32'(irq), 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; m_t = 0; m_act = 1'b0; m_bits = '0;
    m_accepts = 0; m_irqs = 0; dut_irqs = 0;
    reset_n = 1'b1; start = 1'b0; data = '0;

    // Reset, with start ignored while it is held.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    reset_n = 1'b1;
    repeat (2) step();

    // Single frame 16'h5555 with a 1-cycle start pulse.
    base = dut_irqs;
    data = 16'h5555; start = 1'b1;
    step();
    start = 1'b0;
    wait_irq("t2", lat);
    chk("t2_latency", 32'(lat), 32'(EXP_LAT));
    repeat (10) step();
    chk("t2_one_irq", 32'(dut_irqs - base), 32'd1);

    // Continuous start: back-to-back identical frames, start dropped on the third irq.
    base = dut_irqs; acc = m_accepts;
    data = 16'($urandom); start = 1'b1;
    repeat (3) wait_irq("t3", lat);
    start = 1'b0;
    repeat (4) step();
    chk("t3_irqs", 32'(dut_irqs - base), 32'd3);
    chk("t3_irq_vs_frames", 32'(dut_irqs - base), 32'(m_accepts - acc));

    // Data changed mid-frame only affects the next frame.
    base = dut_irqs;
    data = 16'h5555; start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    data = 16'hFFFF; start = 1'b1;
    wait_irq("t4a", lat);
    repeat (2) step();
    start = 1'b0;
    wait_irq("t4b", lat);
    chk("t4b_latency", 32'(lat), 32'(EXP_LAT));
    repeat (3) step();
    chk("t4_irqs", 32'(dut_irqs - base), 32'd2);

    // Last bit on the wire (parity when built, else payload LSB), second half-bit.
    data = 16'h0001; start = 1'b1;
    step();
    start = 1'b0;
    k = (NB - 1) * 2 * C + C;
    repeat (k) step();
    chk("t5_last_bit_0001", 32'(led), 32'(LAST_0001));
    wait_irq("t5a", lat);
    chk("t5a_latency", 32'(k + lat), 32'(EXP_LAT));
    repeat (2) step();
    data = 16'h0003; start = 1'b1;
    step();
    start = 1'b0;
    repeat (k) step();
    chk("t5_last_bit_0003", 32'(led), 32'(LAST_0003));
    wait_irq("t5b", lat);
    chk("t5b_latency", 32'(k + lat), 32'(EXP_LAT));
    repeat (2) step();

    // Reset in the second (high) half of payload bit 5 of 16'h5555.
    data = 16'h5555; start = 1'b1;
    step();
    start = 1'b0;
    repeat ((PB + 5) * 2 * C + C) step();
    chk("t6_led_before_rst", 32'(led), 32'd1);
    base = dut_irqs;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_led", 32'(led), 32'd0);
    chk("t6_rst_irq", 32'(irq), 32'd0);
    start = 1'b1;
    repeat (3) step();
    chk("t6_no_irq", 32'(dut_irqs - base), 32'd0);
    reset_n = 1'b1;
    step();
    start = 1'b0;
    wait_irq("t6", lat);
    chk("t6_latency", 32'(lat), 32'(EXP_LAT));
    repeat (2) step();

    // Randomised frames, start widths, gaps, data churn and occasional aborts.
    for (int i = 0; i < 8; i++) begin
      data = 16'($urandom);
      repeat ($urandom_range(0, 4)) step();
      start = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      start = 1'b0;
      data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, L - 10)) step();
        reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        reset_n = 1'b1;
      end else begin
        repeat (L + 4) step();
      end
    end
    repeat (L + 4) step();
    chk("irq_total", 32'(dut_irqs), 32'(m_irqs));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
